// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial N-bit adder sequencer driving one external
// 1-bit full_adder cell, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into a - b (b inverted, carry-in forced to 1, cin ignored).
module serial_add_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  input  logic         fa_s,
  input  logic         fa_cout,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_sum_sh;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic [CW-1:0]  r_cnt;
  logic           w_accept;
  logic           w_last;
  logic [N-1:0]   w_sum_sh_nxt;
  logic [N-1:0]   w_b_load;
  logic           w_cin_load;

  // Operand B / carry-in as loaded on an accepted start.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load   = sub ? ~b : b;
  assign w_cin_load = sub | cin;
`else
  assign w_b_load   = b;
  assign w_cin_load = cin;
`endif

  // Sum shift register next value: new bit enters at the MSB.
  generate
    if (N == 1) begin : g_sum_w1
      assign w_sum_sh_nxt = fa_s;
    end else begin : g_sum_wn
      assign w_sum_sh_nxt = {fa_s, r_sum_sh[N-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake / full_adder drive outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fa_a        = 1'b0;
    fa_b        = 1'b0;
    fa_cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        fa_a   = r_a[0];
        fa_b   = r_b[0];
        fa_cin = r_carry;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand/sum shifting, carry, bit counter and result registers.
  // The visible result is loaded on the edge entering DONE with the final
  // shift value, so it equals the completed sum register throughout DONE and
  // holds afterwards without a separate DONE-cycle copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= w_b_load;
      r_carry  <= w_cin_load;
      r_cnt    <= '0;
      r_sum_sh <= '0;
    end else if (r_state == S_RUN) begin
      r_sum_sh <= w_sum_sh_nxt;
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_carry  <= fa_cout;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_sum_sh_nxt;
        r_cout <= fa_cout;
        r_ovf  <= fa_cin ^ fa_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
